// File: rtl/packet_sched_pkg.sv
// Shared types and helpers for the packet stream scheduler
// and the round-robin arbiters built on rr_pick.
package packet_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate by ptr,
// priority-encode, rotate the winner back.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  logic [N-1:0] rot;

  always_comb begin
    rot   = '0;
    idx_o = '0;
    any_o = |req_i;
    for (int i = 0; i < N; i++) begin
      rot[i] = req_i[IW'((i + int'(ptr_i)) % N)];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) idx_o = IW'((i + int'(ptr_i)) % N);
    end
  end

endmodule

// File: rtl/packet_stream_scheduler.sv
// Packet-level round-robin mux of N valid/ready streams
// onto one registered output, up to QUANTUM packets per turn.
module packet_stream_scheduler
  import packet_sched_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32,
  parameter int QUANTUM = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          in_valid,
  input  logic [N_PORTS-1:0]          in_last,
  input  logic [N_PORTS*DATA_W-1:0]   in_data,
  output logic [N_PORTS-1:0]          in_ready,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(N_PORTS)-1:0]  out_src,
  input  logic                        out_ready
);

  localparam int IW = $clog2(N_PORTS);
  localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

  typedef logic [IW-1:0] port_idx_t;

  state_t      state_q, state_d;
  port_idx_t   ptr_q, ptr_d;
  port_idx_t   gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        ov_q, ov_d;
  logic        ol_q, ol_d;
  logic [DATA_W-1:0] od_q, od_d;
  port_idx_t   os_q, os_d;

  port_idx_t   pick_idx;
  logic        pick_any;
  logic        sel_valid;
  logic        sel_last;
  logic [DATA_W-1:0] sel_data;
  logic        can_load;

  rr_pick #(.N(N_PORTS)) u_pick (
    .req_i (in_valid),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt_q == IW'(i)) begin
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
        sel_data  = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign can_load = out_ready || !ov_q;

  always_comb begin
    in_ready = '0;
    if (state_q == LOCKED) in_ready[gnt_q] = can_load;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    ol_d    = ol_q;
    od_d    = od_q;
    os_d    = os_q;
    if (ov_q && out_ready) ov_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The port that was mid-turn has nothing queued: its turn ends.
        if (cnt_q != '0 && !in_valid[ptr_q]) begin
          ptr_d = IW'(rr_next(int'(ptr_q), N_PORTS));
          cnt_d = '0;
        end
        if (pick_any) begin
          gnt_d   = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (sel_valid && can_load) begin
          ov_d = 1'b1;
          ol_d = sel_last;
          od_d = sel_data;
          os_d = gnt_q;
          if (sel_last) begin
            state_d = IDLE;
            if (cnt_q == CW'(QUANTUM - 1)) begin
              ptr_d = IW'(rr_next(int'(gnt_q), N_PORTS));
              cnt_d = '0;
            end else begin
              ptr_d = gnt_q;
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      od_q    <= '0;
      os_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
      od_q    <= od_d;
      os_q    <= os_d;
    end
  end

  assign out_valid = ov_q;
  assign out_last  = ol_q;
  assign out_data  = od_q;
  assign out_src   = os_q;

endmodule

// File: tb/tb_packet_stream_scheduler.sv
// Directed bench for packet_stream_scheduler with a
// packet-level round-robin reference model and scoreboard.
module tb_packet_stream_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int Q  = 2;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_last;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic          out_last;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          out_ready;

  packet_stream_scheduler #(
    .N_PORTS (N),
    .DATA_W  (DW),
    .QUANTUM (Q)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nfail = 0;

  logic [DW:0]   pq [N][$];
  logic [DW:0]   mb [N][$];
  logic [DW+2:0] exq[$];
  int            m_order[$];
  int            obs[$];
  int            xq[$];
  int            sent [N];
  int            m_ptr = 0;
  int            m_cnt = 0;
  int            serial = 0;
  int            pause_left = 0;
  bit            or_mode = 0;
  int            ork = 0;
  bit            orp [6] = '{1, 0, 0, 1, 0, 1};
  bit            rec_on = 0;
  int            t1c [9] = '{2, 3, 4, 6, 7, 8, 10, 11, 12};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int enc(input int q[$]);
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i] + 1;
    return v;
  endfunction

  task automatic add_pkt(input int p, input int nb);
    logic [DW:0] b;
    for (int i = 0; i < nb; i++) begin
      b = {(i == nb - 1), 8'(p), 24'(serial)};
      serial++;
      pq[p].push_back(b);
      mb[p].push_back(b);
    end
  endtask

  // Whole-packet round robin: a port keeps its turn while it has
  // another packet ready and has sent fewer than Q in a row.
  function automatic void model_run();
    int p;
    bit more;
    logic [DW:0] b;
    while (1) begin
      more = 0;
      for (int i = 0; i < N; i++) if (mb[i].size() > 0) more = 1;
      if (!more) break;
      if (m_cnt != 0 && mb[m_ptr].size() == 0) begin
        m_ptr = (m_ptr + 1) % N;
        m_cnt = 0;
      end
      p = m_ptr;
      while (mb[p].size() == 0) p = (p + 1) % N;
      m_order.push_back(p);
      do begin
        b = mb[p].pop_front();
        exq.push_back({2'(p), b});
      end while (!b[DW]);
      if (m_cnt == Q - 1) begin
        m_ptr = (p + 1) % N;
        m_cnt = 0;
      end else begin
        m_ptr = p;
        m_cnt++;
      end
    end
  endfunction

  function automatic void model_settle();
    if (m_cnt != 0) begin
      m_ptr = (m_ptr + 1) % N;
      m_cnt = 0;
    end
  endfunction

  task automatic drive();
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;
    for (int p = 0; p < N; p++) begin
      bit hold;
      hold = (p == 0 && pause_left > 0 && sent[0] == 2);
      if (hold) pause_left--;
      if (pq[p].size() > 0 && !hold) begin
        in_valid[p] = 1'b1;
        in_last[p]  = pq[p][0][DW];
        in_data[p*DW +: DW] = pq[p][0][DW-1:0];
      end
    end
    out_ready = or_mode ? orp[ork % 6] : 1'b1;
    ork++;
  endtask

  task automatic tick();
    logic [N-1:0] xf;
    @(negedge clk);
    xf = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (xf[p]) begin
        void'(pq[p].pop_front());
        sent[p]++;
      end
    end
    drive();
  endtask

  function automatic bit all_empty();
    bit e = (exq.size() == 0) && !out_valid;
    for (int p = 0; p < N; p++) if (pq[p].size() > 0) e = 0;
    return e;
  endfunction

  task automatic drain(input string nm);
    int n = 0;
    while (!all_empty() && n < 2000) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, 64'(n < 2000), 1);
    repeat (3) tick();
    model_settle();
  endtask

  task automatic begin_test();
    m_order.delete();
    obs.delete();
    for (int p = 0; p < N; p++) sent[p] = 0;
  endtask

  // Scoreboard and stall-hold checker.
  logic          pv = 0;
  logic          pr = 0;
  logic          pl = 0;
  logic [DW-1:0] pd = '0;
  logic [1:0]    ps = '0;
  bit            inp = 0;

  initial begin
    logic [DW+2:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv  = 0;
        inp = 0;
      end else begin
        chk("in_ready_onehot0", 64'($onehot0(in_ready)), 1);
        if (pv && !pr) begin
          chk("hold_valid", 64'(out_valid), 1);
          chk("hold_data", 64'(out_data), 64'(pd));
          chk("hold_last", 64'(out_last), 64'(pl));
          chk("hold_src", 64'(out_src), 64'(ps));
        end
        if (out_valid && out_ready) begin
          chk("beat_expected", 64'(exq.size() > 0), 1);
          if (exq.size() > 0) begin
            e = exq.pop_front();
            chk("beat_src", 64'(out_src), 64'(e[DW+2:DW+1]));
            chk("beat_last", 64'(out_last), 64'(e[DW]));
            chk("beat_data", 64'(out_data), 64'(e[DW-1:0]));
          end
          if (!inp) obs.push_back(int'(out_src));
          inp = !out_last;
          if (rec_on) xq.push_back(cyc);
        end
        pv = out_valid;
        pr = out_ready;
        pl = out_last;
        pd = out_data;
        ps = out_src;
      end
    end
  end

  initial begin
    int t0;
    int n;
    rst_n = 1'b0;
    for (int p = 0; p < N; p++) sent[p] = 0;
    drive();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 64'(out_valid), 0);
    chk("reset_out_last", 64'(out_last), 0);
    chk("reset_out_data", 64'(out_data), 0);
    chk("reset_out_src", 64'(out_src), 0);
    chk("reset_in_ready", 64'(in_ready), 0);
    @(posedge clk);
    #1;

    // Three ports, one 3-beat packet each: order 0,1,2 with bubbles.
    begin_test();
    add_pkt(0, 3);
    add_pkt(1, 3);
    add_pkt(2, 3);
    model_run();
    chk("t1_model_order", 64'(enc(m_order)), 'h123);
    rec_on = 1;
    drive();
    t0 = cyc;
    drain("t1");
    rec_on = 0;
    chk("t1_order", 64'(enc(obs)), 'h123);
    chk("t1_beats", 64'(xq.size()), 9);
    foreach (xq[i]) if (i < 9) chk("t1_cycle", 64'(xq[i] - t0), 64'(t1c[i]));

    // Reset mid-packet, then port 0 wins from ptr 0.
    begin_test();
    add_pkt(0, 4);
    model_run();
    drive();
    n = 0;
    while (sent[0] < 1 && n < 50) begin
      tick();
      n++;
    end
    chk("t5_started", 64'(sent[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", 64'(out_valid), 0);
    chk("t5_rst_in_ready", 64'(in_ready), 0);
    for (int p = 0; p < N; p++) begin
      pq[p].delete();
      mb[p].delete();
    end
    exq.delete();
    m_ptr = 0;
    m_cnt = 0;
    drive();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    begin_test();
    add_pkt(2, 2);
    add_pkt(0, 2);
    model_run();
    chk("t5_model_order", 64'(enc(m_order)), 'h13);
    drive();
    drain("t5");
    chk("t5_order", 64'(enc(obs)), 'h13);

    // ptr now 3: ports 0 and 3 request, 3 first then wrap to 0.
    begin_test();
    add_pkt(0, 2);
    add_pkt(3, 1);
    model_run();
    chk("t6_model_order", 64'(enc(m_order)), 'h41);
    drive();
    drain("t6");
    chk("t6_order", 64'(enc(obs)), 'h41);

    // Quantum 2: port 1 has three packets, port 3 one.
    begin_test();
    add_pkt(1, 1);
    add_pkt(1, 1);
    add_pkt(1, 1);
    add_pkt(3, 1);
    model_run();
    chk("t2_model_order", 64'(enc(m_order)), 'h2242);
    drive();
    drain("t2");
    chk("t2_order", 64'(enc(obs)), 'h2242);

    // Port 2 four beats under a stalling sink.
    begin_test();
    or_mode = 1;
    ork = 0;
    add_pkt(2, 4);
    model_run();
    chk("t3_model_order", 64'(enc(m_order)), 'h3);
    drive();
    drain("t3");
    or_mode = 0;
    chk("t3_order", 64'(enc(obs)), 'h3);

    // Port 0 pauses mid-packet while port 1 waits.
    begin_test();
    add_pkt(0, 4);
    add_pkt(1, 2);
    pause_left = 5;
    model_run();
    chk("t4_model_order", 64'(enc(m_order)), 'h12);
    drive();
    drain("t4");
    chk("t4_order", 64'(enc(obs)), 'h12);
    chk("t4_pause_used", 64'(pause_left), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
